// File: rtl/adder_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : adder_operand_loader
//  Description : Operand-entry stage for the 3-bit ripple adder. Captures
//                operand A and then operand B from the slide switches on
//                successive LOAD presses, then offers the pair to the adder
//                with a valid/ready handshake. The operands stay on the
//                outputs after acceptance so the SUM can be shown on the LEDs.
//  Options     : DEBOUNCE_EN - when defined, each button must hold a new level
//                for DEBOUNCE_CYCLES cycles before it is believed. When it is
//                undefined, the synchronized level is used directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_operand_loader #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             btn_load,
  input  logic             btn_clear,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  output logic [1:0]       state_led
);

  typedef enum logic [1:0] {
    ST_GET_A = 2'b00,
    ST_GET_B = 2'b01,
    ST_VALID = 2'b10,
    ST_SHOW  = 2'b11
  } state_t;

  // Button vector index: bit 0 is LOAD and bit 1 is CLEAR.
  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;
  logic [1:0]       r_btn_s1;
  logic [1:0]       r_btn_s2;
  logic [1:0]       w_level;
  logic [1:0]       r_level_q;
  logic [1:0]       r_press;
  logic             w_press_load;
  logic             w_press_clear;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_valid;
  logic [WIDTH-1:0] w_op_a_nxt;
  logic [WIDTH-1:0] w_op_b_nxt;
  logic             w_op_valid_nxt;

  // Two-flop synchronizers for the switches and both buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= {btn_clear, btn_load};
      r_btn_s2 <= r_btn_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;

      // Count cycles that the synced level disagrees with the stable level.
      // The count resets as soon as they agree again, so a bounce restarts
      // the wait. The count stops at c_cnt_max, where the new level is taken.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_btn_s2[gi] == r_stable) begin
          r_cnt    <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_cnt    <= '0;
          r_stable <= r_btn_s2[gi];
        end else begin
          r_cnt    <= r_cnt + 1'b1;
        end
      end

      assign w_level[gi] = r_stable;
    end
  endgenerate
`else
  assign w_level = r_btn_s2;
`endif

  // Rising edge of the stable level becomes a one-cycle press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level_q <= '0;
      r_press   <= '0;
    end else begin
      r_level_q <= w_level;
      r_press   <= w_level & ~r_level_q;
    end
  end

  assign w_press_load  = r_press[0];
  assign w_press_clear = r_press[1];

  // Next state and next operand values. CLEAR overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    if (w_press_clear) begin
      w_state_nxt = ST_GET_A;
      w_op_a_nxt  = '0;
      w_op_b_nxt  = '0;
    end else begin
      case (r_state)
        ST_GET_A, ST_SHOW: begin
          if (w_press_load) begin
            w_op_a_nxt  = r_sw_s2;
            w_op_b_nxt  = '0;
            w_state_nxt = ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (w_press_load) begin
            w_op_b_nxt  = r_sw_s2;
            w_state_nxt = ST_VALID;
          end
        end
        ST_VALID: begin
          // LOAD is ignored here. The pair only leaves on a transfer.
          if (r_op_valid && op_ready) begin
            w_state_nxt = ST_SHOW;
          end
        end
        default: begin
          w_state_nxt = ST_GET_A;
        end
      endcase
    end
    // op_valid is registered, so it follows the state being entered.
    w_op_valid_nxt = (w_state_nxt == ST_VALID);
  end

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_GET_A;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_a     <= w_op_a_nxt;
      r_op_b     <= w_op_b_nxt;
      r_op_valid <= w_op_valid_nxt;
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_valid  = r_op_valid;
  assign state_led = r_state;

endmodule
`default_nettype wire
